instr_fetch_unit: RTL

Instruction fetch front-end for the 17-bit ASIP. It drives the program counter, reads the instruction memory over a req/ack handshake, and holds each fetched word in a one-entry buffer until the controller/datapath accepts it. Taken branches arrive as `pc_src` plus `branch_target` from the datapath and redirect the fetch stream, squashing wrong-path words. It sits between the instruction memory and the `controller`/datapath `Instr` input.

---
 rtl/asip_pkg.sv | 21 ++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/asip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asip_pkg
// Description : Shared widths and types for the 17-bit ASIP front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package asip_pkg;

    localparam int INSTR_W = 17;
    localparam int PC_W    = 16;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage : asip_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC sequencing, req/ack instruction fetch, one-entry buffer and
//               branch redirect with wrong-path squashing.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import asip_pkg::*;
#(
    parameter int              PC_W     = asip_pkg::PC_W,
    parameter int              INSTR_W  = asip_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               pc_src,
    input  logic [PC_W-1:0]    branch_target
);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    req_addr;
    logic [PC_W-1:0]    req_addr_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic [PC_W-1:0]    instr_pc_nxt;
    logic               instr_valid_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_addr    <= req_addr_nxt;
            instr_valid <= instr_valid_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        req_addr_nxt    = req_addr;
        instr_valid_nxt = instr_valid;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;

        unique case (state)
            FETCH: begin
                if (imem_ack && pc_src) begin
                    // Redirect coincides with the returning word: drop it and
                    // issue the target immediately.
                    req_addr_nxt = branch_target;
                    pc_nxt       = branch_target;
                end else if (imem_ack) begin
                    instr_nxt       = imem_rdata;
                    instr_pc_nxt    = req_addr;
                    instr_valid_nxt = 1'b1;
                    pc_nxt          = req_addr + PC_W'(1);
                    state_nxt       = HOLD;
                end else if (pc_src) begin
                    // Outstanding request cannot be withdrawn; drain it first.
                    pc_nxt    = branch_target;
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (pc_src) begin
                    pc_nxt = branch_target;
                end
                if (imem_ack) begin
                    req_addr_nxt = pc_src ? branch_target : pc;
                    state_nxt    = FETCH;
                end
            end
            HOLD: begin
                if (pc_src) begin
                    instr_valid_nxt = 1'b0;
                    pc_nxt          = branch_target;
                    req_addr_nxt    = branch_target;
                    state_nxt       = FETCH;
                end else if (instr_ready) begin
                    instr_valid_nxt = 1'b0;
                    req_addr_nxt    = pc;
                    state_nxt       = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Reset gates the request so the memory never sees one during reset.
    assign imem_req  = reset && ((state == FETCH) || (state == DISCARD));
    assign imem_addr = req_addr;

endmodule : instr_fetch_unit
`default_nettype wire
